// File: rtl/eth_rx_frame_fifo_if.sv
// Byte-wide AXI-stream bundle used on both sides of the receive frame buffer.
// The master drives data/valid/last/user; the slave drives ready.
interface eth_rx_frame_fifo_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame buffer: frames commit only after a clean tlast.
// Optional saturating statistics counters are enabled by defining ETH_RX_FIFO_STATS_EN.
module eth_rx_frame_fifo #(
    parameter int DEPTH_LOG2     = 12,
    parameter int DROP_BAD_FRAME = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    eth_rx_frame_fifo_if.slave         s_axis,
    eth_rx_frame_fifo_if.master        m_axis,
    output logic                       status_good_frame,
    output logic                       status_bad_frame,
    output logic                       status_overflow,
    output logic [15:0]                stat_good_count,
    output logic [15:0]                stat_bad_count,
    output logic [15:0]                stat_overflow_count
);

    localparam int             DEPTH     = 1 << DEPTH_LOG2;
    localparam int             PW        = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]  FULL_DIST = PW'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
    localparam logic           DROP_BAD  = (DROP_BAD_FRAME != 0);
    localparam logic           KEEP_USER = (DROP_BAD_FRAME == 0);

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_t;

    wr_state_t       r_state;
    wr_state_t       w_state_nxt;
    logic [PW-1:0]   r_wr_cur;
    logic [PW-1:0]   r_wr_commit;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   w_wr_cur_nxt;
    logic [PW-1:0]   w_wr_commit_nxt;
    logic            w_wr_en;
    logic            w_good;
    logic            w_bad;
    logic            w_ovf;
    logic            w_full;
    logic            w_empty;
    logic            w_load;
    logic [9:0]      w_wr_word;
    logic [9:0]      r_mem [DEPTH];
    logic            r_m_valid;
    logic [7:0]      r_m_data;
    logic            r_m_last;
    logic            r_m_user;
    logic            r_good;
    logic            r_bad;
    logic            r_ovf;

    // The MAC cannot be stalled, so the input is always ready.
    assign s_axis.tready = 1'b1;

    assign w_full    = ((r_wr_cur - r_rd) == FULL_DIST);
    assign w_empty   = (r_rd == r_wr_commit);
    assign w_load    = !w_empty && (!r_m_valid || m_axis.tready);
    assign w_wr_word = {s_axis.tuser & s_axis.tlast & KEEP_USER, s_axis.tlast, s_axis.tdata};

    // Write FSM next-state, pointer updates and frame verdict pulses.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_cur_nxt    = r_wr_cur;
        w_wr_commit_nxt = r_wr_commit;
        w_wr_en         = 1'b0;
        w_good          = 1'b0;
        w_bad           = 1'b0;
        w_ovf           = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                if (s_axis.tvalid) begin
                    if (w_full) begin
                        // Rewind the partial frame; a full buffer on tlast ends the frame here.
                        w_wr_cur_nxt = r_wr_commit;
                        if (s_axis.tlast) begin
                            w_ovf = 1'b1;
                        end else begin
                            w_state_nxt = ST_DROP;
                        end
                    end else begin
                        w_wr_en = 1'b1;
                        if (s_axis.tlast && s_axis.tuser && DROP_BAD) begin
                            w_wr_cur_nxt = r_wr_commit;
                            w_bad        = 1'b1;
                        end else if (s_axis.tlast) begin
                            w_wr_cur_nxt    = r_wr_cur + PTR_ONE;
                            w_wr_commit_nxt = r_wr_cur + PTR_ONE;
                            w_good          = 1'b1;
                        end else begin
                            w_wr_cur_nxt = r_wr_cur + PTR_ONE;
                        end
                    end
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_DROP: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    w_ovf       = 1'b1;
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    // Write FSM state, write pointers and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACTIVE;
            r_wr_cur    <= '0;
            r_wr_commit <= '0;
            r_good      <= 1'b0;
            r_bad       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_cur    <= w_wr_cur_nxt;
            r_wr_commit <= w_wr_commit_nxt;
            r_good      <= w_good;
            r_bad       <= w_bad;
            r_ovf       <= w_ovf;
        end
    end

    // Frame storage write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_cur[DEPTH_LOG2-1:0]] <= w_wr_word;
        end
    end

    // Synchronous read straight into the output register; it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd      <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= 8'h00;
            r_m_last  <= 1'b0;
            r_m_user  <= 1'b0;
        end else if (w_load) begin
            r_rd                           <= r_rd + PTR_ONE;
            r_m_valid                      <= 1'b1;
            {r_m_user, r_m_last, r_m_data} <= r_mem[r_rd[DEPTH_LOG2-1:0]];
        end else if (m_axis.tready) begin
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= r_m_valid;
        end
    end

    assign m_axis.tvalid     = r_m_valid;
    assign m_axis.tdata      = r_m_data;
    assign m_axis.tlast      = r_m_last;
    assign m_axis.tuser      = r_m_user;
    assign status_good_frame = r_good;
    assign status_bad_frame  = r_bad;
    assign status_overflow   = r_ovf;

`ifdef ETH_RX_FIFO_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;
    logic [15:0] r_ovf_cnt;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt <= 16'h0000;
            r_bad_cnt  <= 16'h0000;
            r_ovf_cnt  <= 16'h0000;
        end else begin
            if (w_good && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_bad && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
            if (w_ovf && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign stat_good_count     = r_good_cnt;
    assign stat_bad_count      = r_bad_cnt;
    assign stat_overflow_count = r_ovf_cnt;
`else
    assign stat_good_count     = 16'h0000;
    assign stat_bad_count      = 16'h0000;
    assign stat_overflow_count = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Bench for eth_rx_frame_fifo: dut_a (64 bytes, bad frames dropped) and dut_b (4 KiB, bad frames forwarded).
// Expected beats and frame verdicts come from a frame-level model with scoreboard queues.
module tb_eth_rx_frame_fifo;

    localparam int K_GOOD = 0;
    localparam int K_BAD  = 1;
    localparam int K_OVF  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_rx_frame_fifo_if sa ();
    eth_rx_frame_fifo_if ma ();
    eth_rx_frame_fifo_if sb ();
    eth_rx_frame_fifo_if mb ();

    logic        a_good, a_bad, a_ovf, b_good, b_bad, b_ovf;
    logic [15:0] a_cg, a_cb, a_co, b_cg, b_cb, b_co;

    eth_rx_frame_fifo #(.DEPTH_LOG2(6), .DROP_BAD_FRAME(1)) dut_a (
        .clk(clk), .rst(rst), .s_axis(sa), .m_axis(ma),
        .status_good_frame(a_good), .status_bad_frame(a_bad), .status_overflow(a_ovf),
        .stat_good_count(a_cg), .stat_bad_count(a_cb), .stat_overflow_count(a_co));

    eth_rx_frame_fifo #(.DEPTH_LOG2(12), .DROP_BAD_FRAME(0)) dut_b (
        .clk(clk), .rst(rst), .s_axis(sb), .m_axis(mb),
        .status_good_frame(b_good), .status_bad_frame(b_bad), .status_overflow(b_ovf),
        .stat_good_count(b_cg), .stat_bad_count(b_cb), .stat_overflow_count(b_co));

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    int a_good_n = 0, a_bad_n = 0, a_ovf_n = 0, b_good_n = 0, b_bad_n = 0, b_ovf_n = 0;
    int a_eg = 0, a_eb = 0, a_eo = 0, b_eg = 0, b_eb = 0, b_eo = 0;
    int a_sg = 0, a_sb = 0, a_so = 0, b_sg = 0;
    logic [9:0] a_prev, b_prev;
    bit a_stall = 1'b0, b_stall = 1'b0;
    bit b_rand = 1'b0;

    typedef struct {
        int   len;
        logic user;
        int   kind;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level verdict: a frame that needs more room than is free overflows, else tuser decides.
    function automatic int frame_kind(input int len, input logic user, input int free, input logic drop_bad);
        if (len > free) return K_OVF;
        if (user && drop_bad) return K_BAD;
        return K_GOOD;
    endfunction

    // Output monitor and hold-while-stalled check for dut_a.
    always @(negedge clk) begin
        if (rst) begin
            a_stall = 1'b0;
        end else begin
            if (a_stall)
                check("a_hold", {ma.tvalid, ma.tuser, ma.tlast, ma.tdata}, {1'b1, a_prev});
            if (ma.tvalid && ma.tready) begin
                if (exp_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL a_extra_beat: got 0x%0h, required no beat", {ma.tuser, ma.tlast, ma.tdata});
                end else begin
                    check("a_beat", {ma.tuser, ma.tlast, ma.tdata}, exp_a.pop_front());
                end
            end
            a_prev  = {ma.tuser, ma.tlast, ma.tdata};
            a_stall = ma.tvalid && !ma.tready;
            a_good_n += int'(a_good); a_bad_n += int'(a_bad); a_ovf_n += int'(a_ovf);
        end
    end

    // Output monitor and hold-while-stalled check for dut_b.
    always @(negedge clk) begin
        if (rst) begin
            b_stall = 1'b0;
        end else begin
            if (b_stall)
                check("b_hold", {mb.tvalid, mb.tuser, mb.tlast, mb.tdata}, {1'b1, b_prev});
            if (mb.tvalid && mb.tready) begin
                if (exp_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL b_extra_beat: got 0x%0h, required no beat", {mb.tuser, mb.tlast, mb.tdata});
                end else begin
                    check("b_beat", {mb.tuser, mb.tlast, mb.tdata}, exp_b.pop_front());
                end
            end
            b_prev  = {mb.tuser, mb.tlast, mb.tdata};
            b_stall = mb.tvalid && !mb.tready;
            b_good_n += int'(b_good); b_bad_n += int'(b_bad); b_ovf_n += int'(b_ovf);
        end
    end

    // Random 50% backpressure on dut_b when enabled.
    always @(posedge clk) begin
        #1;
        mb.tready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
        sa.tvalid = 1'b0; sb.tvalid = 1'b0;
        exp_a.delete(); exp_b.delete();
        a_sg = 0; a_sb = 0; a_so = 0; b_sg = 0;
    endtask

    task automatic send_frame_a(input int len, input logic user, input int kind, input logic [7:0] base, input bit rnd);
        logic [9:0] beats[$];
        logic [7:0] d;
        logic       l;
        for (int j = 0; j < len; j++) begin
            d = rnd ? 8'($urandom) : base + 8'(j);
            l = (j == len - 1);
            sa.tvalid = 1'b1; sa.tdata = d; sa.tlast = l;
            sa.tuser  = l ? user : 1'($urandom);
            beats.push_back({1'b0, l, d});
            idle(1);
        end
        sa.tvalid = 1'b0;
        if (kind == K_GOOD) begin
            foreach (beats[k]) exp_a.push_back(beats[k]);
            a_eg++; a_sg++;
        end else if (kind == K_BAD) begin
            a_eb++; a_sb++;
        end else begin
            a_eo++; a_so++;
        end
    endtask

    task automatic send_frame_b(input int len, input logic user);
        logic [7:0] d;
        logic       l;
        for (int j = 0; j < len; j++) begin
            d = 8'($urandom);
            l = (j == len - 1);
            sb.tvalid = 1'b1; sb.tdata = d; sb.tlast = l;
            sb.tuser  = l ? user : 1'($urandom);
            exp_b.push_back({l & user, l, d});
            idle(1);
        end
        sb.tvalid = 1'b0;
        b_eg++; b_sg++;
    endtask

    task automatic wait_drain_a(input string tag);
        for (int i = 0; i < 600; i++) begin
            if (exp_a.size() == 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check({tag, "_drain_left"}, exp_a.size(), 0);
        check({tag, "_idle_valid"}, ma.tvalid, 0);
        check({tag, "_good_cnt"}, a_good_n, a_eg);
        check({tag, "_bad_cnt"}, a_bad_n, a_eb);
        check({tag, "_ovf_cnt"}, a_ovf_n, a_eo);
        @(posedge clk); #1;
    endtask

    task automatic check_stats_a(input string tag);
`ifdef ETH_RX_FIFO_STATS_EN
        check({tag, "_stat_good"}, a_cg, a_sg);
        check({tag, "_stat_bad"}, a_cb, a_sb);
        check({tag, "_stat_ovf"}, a_co, a_so);
`else
        check({tag, "_stat_off"}, {a_cg, a_cb | a_co}, 0);
`endif
    endtask

    int used;
    int k;

    initial begin
        tbl[0] = '{len: 5,   user: 1'b0, kind: K_GOOD};
        tbl[1] = '{len: 64,  user: 1'b0, kind: K_GOOD};
        tbl[2] = '{len: 65,  user: 1'b0, kind: K_OVF};
        tbl[3] = '{len: 64,  user: 1'b1, kind: K_BAD};
        tbl[4] = '{len: 1,   user: 1'b0, kind: K_GOOD};
        tbl[5] = '{len: 100, user: 1'b0, kind: K_OVF};
        tbl[6] = '{len: 2,   user: 1'b1, kind: K_BAD};
        tbl[7] = '{len: 30,  user: 1'b0, kind: K_GOOD};

        sa.tvalid = 1'b0; sa.tdata = 8'h00; sa.tlast = 1'b0; sa.tuser = 1'b0;
        sb.tvalid = 1'b0; sb.tdata = 8'h00; sb.tlast = 1'b0; sb.tuser = 1'b0;
        ma.tready = 1'b1;
        rst = 1'b1;
        #1;
        do_reset(3);

        check("rst_a_out", {ma.tvalid, ma.tuser, ma.tlast, ma.tdata}, 0);
        check("rst_b_out", {mb.tvalid, mb.tuser, mb.tlast, mb.tdata}, 0);
        check("rst_status", {a_good, a_bad, a_ovf, b_good, b_bad, b_ovf}, 0);
        check("rst_stats_a", {a_cg, a_cb | a_co}, 0);

        // Good 64-byte frame: tvalid one cycle after the tlast edge.
        send_frame_a(64, 1'b0, K_GOOD, 8'h00, 1'b0);
        @(negedge clk);
        check("lat_e0_valid", ma.tvalid, 0);
        check("lat_e0_good_pulse", a_good, 1);
        @(negedge clk);
        check("lat_e1_valid", ma.tvalid, 1);
        check("lat_e1_data", ma.tdata, 8'h00);
        check("lat_e1_pulse_gone", a_good, 0);
        @(posedge clk); #1;
        wait_drain_a("good64");

        for (int i = 0; i < 8; i++) begin
            send_frame_a(tbl[i].len, tbl[i].user, tbl[i].kind, 8'(i * 16), 1'b0);
            idle(2);
            wait_drain_a($sformatf("tbl%0d", i));
        end
        check_stats_a("tbl");

        // Overflow with the output stalled: one byte sits in the output register.
        do_reset(2);
        ma.tready = 1'b0;
        used = 0;
        k = frame_kind(40, 1'b0, 64 - used, 1'b1); send_frame_a(40, 1'b0, k, 8'h00, 1'b0); idle(3);
        used = 39;
        k = frame_kind(40, 1'b0, 64 - used, 1'b1); send_frame_a(40, 1'b0, k, 8'h80, 1'b0); idle(3);
        k = frame_kind(25, 1'b0, 64 - used, 1'b1); send_frame_a(25, 1'b0, k, 8'h40, 1'b0); idle(3);
        used = used + 25;
        k = frame_kind(1, 1'b0, 64 - used, 1'b1); send_frame_a(1, 1'b0, k, 8'hF0, 1'b0); idle(3);
        @(negedge clk);
        check("ovf_good_cnt", a_good_n, a_eg);
        check("ovf_ovf_cnt", a_ovf_n, a_eo);
        check("ovf_held_beat", {ma.tvalid, ma.tdata}, {1'b1, 8'h00});
        @(posedge clk); #1;
        ma.tready = 1'b1;
        wait_drain_a("ovf_release");
        send_frame_a(20, 1'b0, K_GOOD, 8'h60, 1'b0);
        wait_drain_a("ovf_after");
        check_stats_a("ovf");

        // Reset in the middle of a frame with a committed beat waiting at the output.
        ma.tready = 1'b0;
        send_frame_a(8, 1'b0, K_GOOD, 8'hA0, 1'b0);
        idle(3);
        check("rstmid_pre_valid", ma.tvalid, 1);
        for (int j = 0; j < 10; j++) begin
            sa.tvalid = 1'b1; sa.tdata = 8'(j); sa.tlast = 1'b0; sa.tuser = 1'b0;
            idle(1);
        end
        sa.tdata = 8'd10;
        do_reset(1);
        check("rstmid_valid", ma.tvalid, 0);
        ma.tready = 1'b1;
        send_frame_a(25, 1'b0, K_GOOD, 8'd19, 1'b0);
        wait_drain_a("rstmid");

        // Pointer wrap: 100 back-to-back 17-byte frames.
        do_reset(2);
        for (int i = 0; i < 100; i++) begin
            send_frame_a(17, 1'b0, frame_kind(17, 1'b0, 47, 1'b1), 8'h00, 1'b1);
        end
        wait_drain_a("wrap");
        check_stats_a("wrap");

        // dut_b: tuser forwarded, back-to-back frames, random backpressure.
        b_rand = 1'b1;
        send_frame_b(64, 1'b1);
        for (int i = 0; i < 3; i++) send_frame_b(60, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send_frame_b(int'($urandom_range(1, 80)), 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 6000; i++) begin
            if (exp_b.size() == 0) break;
            @(negedge clk);
        end
        b_rand = 1'b0;
        repeat (4) @(negedge clk);
        check("b_drain_left", exp_b.size(), 0);
        check("b_good_cnt", b_good_n, b_eg);
        check("b_bad_cnt", b_bad_n, b_eb);
        check("b_ovf_cnt", b_ovf_n, b_eo);
`ifdef ETH_RX_FIFO_STATS_EN
        check("b_stat_good", b_cg, b_sg);
        check("b_stat_bad_ovf", {b_cb, b_co}, 0);
`else
        check("b_stat_off", {b_cg, b_cb | b_co}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got no end of test, required end before 900000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/eth_rx_frame_fifo.md
# eth_rx_frame_fifo

Store-and-forward receive frame buffer placed directly downstream of the 1G RGMII MAC's receive AXI-stream output, in the MAC receive clock domain. The MAC output has no backpressure, so this block absorbs every byte and commits a frame only after its last byte arrives clean. Frames flagged bad by the MAC (tuser on tlast) or overflowing the buffer are discarded whole. Committed frames are replayed on a backpressured AXI-stream master toward the host DMA/CSR path.

## Interface
- DEPTH_LOG2, 12: buffer depth is 2^DEPTH_LOG2 bytes. Legal range 6..16.
- DROP_BAD_FRAME, 1: 1 discards frames with tuser set on tlast; 0 commits them and forwards tuser on m_axis_tlast beat.
- clk  in  1  receive clock (MAC rx_clk); all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  8  byte from MAC.
- s_axis_tvalid  in  1  byte valid; no tready exists, so a byte is taken every cycle tvalid is high.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  frame error; sampled only with tlast.
- m_axis_tdata  out  8  output byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last byte of frame.
- m_axis_tuser  out  1  error flag; constant 0 when DROP_BAD_FRAME=1.
- status_good_frame  out  1  one-cycle pulse per committed frame.
- status_bad_frame  out  1  one-cycle pulse per frame dropped for tuser.
- status_overflow  out  1  one-cycle pulse per frame dropped for overflow.
- stat_good_count, stat_bad_count, stat_overflow_count  out  16 each  saturating counters (see Configuration).

## Operation
- Storage: 2^DEPTH_LOG2 x 10-bit RAM holding {tuser, tlast, data}; synchronous read.
- Pointers are DEPTH_LOG2+1 bits: wr_ptr_cur, wr_ptr_commit, rd_ptr. Full when wr_ptr_cur - rd_ptr == 2^DEPTH_LOG2. Empty when rd_ptr == wr_ptr_commit. Wrap is modulo 2^(DEPTH_LOG2+1).
- Write FSM has two states, IDLE/ACTIVE (frame in progress) and DROP.
  - ACTIVE: on each valid byte, if not full, write it and increment wr_ptr_cur. If full, set wr_ptr_cur = wr_ptr_commit and go to DROP. If that byte is tlast, pulse status_overflow the same edge and stay in ACTIVE.
  - ACTIVE with tlast accepted: if tuser=1 and DROP_BAD_FRAME=1, set wr_ptr_cur = wr_ptr_commit and pulse status_bad_frame. Otherwise set wr_ptr_commit = wr_ptr_cur+1 and pulse status_good_frame.
  - DROP: discard bytes. On tlast, pulse status_overflow and return to ACTIVE.
- Read: the output register loads from RAM[rd_ptr] and rd_ptr increments when not empty and (!m_axis_tvalid or m_axis_tready). m_axis_tvalid clears when accepted with nothing left to load.
- Frames longer than 2^DEPTH_LOG2 always overflow and are dropped.

## Timing
- Reset values:
  - all pointers 0; write FSM ACTIVE.
  - m_axis_tvalid, tdata, tlast, tuser all 0.
  - all status pulses 0; counters 0.
- A frame in flight at reset is lost. Bytes arriving after reset without a preceding tlast form a new frame.
- Latency: tlast accepted at edge E0 gives m_axis_tvalid high after E1 (1 cycle), provided the output register is empty.
- Throughput: one byte per cycle while m_axis_tready=1.
- Full is computed from the pre-edge rd_ptr. A read and a write on the same edge at full still count as overflow.
- Commit and a read of the last previously committed byte on the same edge: the new frame is visible on the next edge with no bubble beyond 1 cycle.
- m_axis_tdata/tlast/tuser hold stable while tvalid=1 and tready=0.

## Configuration
- ETH_RX_FIFO_STATS_EN defined: the three 16-bit counters increment on their matching status pulse and saturate at 0xFFFF. They clear only on rst.
- Not defined: counter logic is omitted and the three counter outputs are tied to 0. Status pulses are unaffected.

## Test plan
- Good frame: 64-byte frame 0x00..0x3F, tuser=0, tready=1 → 64 identical bytes out, tlast on 0x3F, tvalid 1 cycle after input tlast, status_good_frame one pulse.
- Bad frame: 64-byte frame with tuser=1 on tlast, DROP_BAD_FRAME=1 → no output bytes, status_bad_frame one pulse, next good frame delivered intact. With DROP_BAD_FRAME=0 → frame delivered with m_axis_tuser=1 on last byte.
- Overflow: DEPTH_LOG2=6, tready=0.
  - 40-byte good frame → committed.
  - Then 40-byte frame → status_overflow pulse at its tlast.
  - Release tready → only the first 40 bytes out.
  - A following 20-byte frame is delivered.
- Backpressure: three back-to-back 60-byte frames, tready random 50% → byte order and tlast positions exact, no loss, outputs stable while stalled.
- Wrap-around: DEPTH_LOG2=6, 100 frames of 17 bytes with tready=1 → all delivered, pointers wrap cleanly, stat_good_count=100 with ETH_RX_FIFO_STATS_EN.
- Reset mid-frame: rst asserted at byte 10 of a frame → m_axis_tvalid=0 next cycle. Input resumes at byte 20 up to tlast (44 bytes total) → delivered as one 25-byte frame.
